// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl_if
//  Description : Load/busy handshake bundle between the value producer and
//                the display scan controller.
//                  val_in   - unsigned binary value to display
//                  load     - convert request, honoured only while busy=0
//                  busy     - conversion in progress
//                  done     - one-cycle pulse when new digits become visible
//                  overflow - last accepted value did not fit the display
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if #(
  parameter int IN_W = 14
) ();
  logic [IN_W-1:0] val_in;
  logic            load;
  logic            busy;
  logic            done;
  logic            overflow;

  // Producer side.
  modport master (
    output val_in, load,
    input  busy, done, overflow
  );

  // Display controller side.
  modport slave (
    input  val_in, load,
    output busy, done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Multi-digit common-anode 7-segment sequencer. A value taken
//                over the load/busy handshake is converted to BCD one bit per
//                cycle (shift-add-3), then committed atomically to the digit
//                register. Digits are time-multiplexed onto one shared
//                seven_seg decoder with an active-low one-hot anode select.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                bus      - handshake bundle (slave side)
//                bcd_cur  - digit code for the shared decoder, 4'hF = blank
//                an       - active-low one-hot anode enable, bit 0 = LSD
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int IN_W     = 14,
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  display_scan_ctrl_if.slave        bus,
  output logic [3:0]                bcd_cur,
  output logic [DIGITS-1:0]         an
);

  localparam int c_acc_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(IN_W + 1);
  localparam int c_idx_w = $clog2(DIGITS);
  localparam int c_pre_w = $clog2(SCAN_DIV);

  localparam logic [63:0]        c_limit     = 64'(10 ** DIGITS);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(IN_W - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DIGITS - 1);
  localparam logic [c_pre_w-1:0] c_last_pre  = c_pre_w'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_last_step;

  logic [IN_W-1:0]      r_sr;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_bitcnt;
  logic                 r_ovf_next;
  logic [c_acc_w-1:0]   r_digits;
  logic                 r_ovf;
  logic                 r_done;

  logic [c_pre_w-1:0]   r_pre;
  logic [c_idx_w-1:0]   r_idx;

  logic [c_acc_w-1:0]   w_acc_adj;
  logic [c_acc_w-1:0]   w_acc_next;
  logic [IN_W-1:0]      w_sr_next;
  logic                 w_unused_msb;

  logic [DIGITS:0]      w_lead;
  logic [DIGITS-1:0]    w_blank;
  logic [3:0]           w_dig [DIGITS];
  logic [3:0]           w_code;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          w_accept     = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (r_bitcnt == c_last_step) begin
          w_last_step  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-add-3: correct every BCD digit >= 5 before shifting the next
  // binary bit in, so the shift never produces a digit above 9.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
    assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                  r_acc[gi*4 +: 4] + 4'd3 : r_acc[gi*4 +: 4];
  end

  // The carry out of the top digit only matters for out-of-range values,
  // which are caught by the range compare at acceptance instead.
  assign w_unused_msb = w_acc_adj[c_acc_w-1];
  assign w_acc_next   = {w_acc_adj[c_acc_w-2:0], r_sr[IN_W-1]};
  assign w_sr_next    = {r_sr[IN_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_acc      <= '0;
      r_bitcnt   <= '0;
      r_ovf_next <= 1'b0;
      r_digits   <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last_step;
      if (w_accept) begin
        r_sr       <= bus.val_in;
        r_acc      <= '0;
        r_bitcnt   <= '0;
        r_ovf_next <= (64'(bus.val_in) >= c_limit);
      end else if (r_state == S_CONV) begin
        r_sr     <= w_sr_next;
        r_acc    <= w_acc_next;
        r_bitcnt <= r_bitcnt + c_cnt_w'(1);
      end
      // Atomic commit: the visible digits only ever change here.
      if (w_last_step) begin
        r_digits <= r_ovf_next ? '0 : w_acc_next;
        r_ovf    <= r_ovf_next;
      end
    end
  end

  assign bus.busy     = (r_state == S_CONV);
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;

  // --------------------------------------------------------------------------
  // Scan prescaler and digit index, free-running regardless of conversion
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_last_pre) begin
      r_pre <= '0;
      r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
    end else begin
      r_pre <= r_pre + c_pre_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero blanking: w_lead[i] is set when digit i and every digit
  // above it are zero. Digit 0 is always shown so zero reads as "0".
  // --------------------------------------------------------------------------
  assign w_lead[DIGITS] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lead
    assign w_dig[gi]   = r_digits[gi*4 +: 4];
    assign w_lead[gi]  = w_lead[gi+1] & (r_digits[gi*4 +: 4] == 4'd0);
    assign w_blank[gi] = (LZB != 0) && (gi != 0) && w_lead[gi];
  end

  always_comb begin
    w_code = w_dig[r_idx];
    if (r_ovf || w_blank[r_idx]) w_code = 4'hF;
  end

  // Registered display outputs (one cycle behind index/digit register).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_cur <= 4'd0;
      an      <= ~DIGITS'(1);
    end else begin
      bcd_cur <= w_code;
      an      <= ~(DIGITS'(1) << r_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_ctrl
//  Description : Self-checking bench for display_scan_ctrl (DIGITS=4,
//                IN_W=14, SCAN_DIV=4, LZB=1). Expected display contents are
//                queued when a load is driven and popped on the done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd_cur;
  logic [3:0] an;

  display_scan_ctrl_if #(.IN_W(14)) bus ();

  display_scan_ctrl #(
    .DIGITS   (4),
    .IN_W     (14),
    .SCAN_DIV (4),
    .LZB      (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .bcd_cur (bcd_cur),
    .an      (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp;
  int          n_err;
  logic [3:0]  cur_disp [4];
  logic        cur_ovf;
  logic [16:0] sb_q [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Bit 16 = overflow, [15:0] = four display codes, digit 0 in [3:0].
  function automatic logic [16:0] model(input int v);
    logic [15:0] d;
    int nd;
    int t;
    if (v >= 10000) return {1'b1, 16'hFFFF};
    nd = 1;
    t  = v;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    t = v;
    for (int i = 0; i < 4; i++) begin
      d[i*4 +: 4] = (i < nd) ? 4'(t % 10) : 4'hF;
      t = t / 10;
    end
    return {1'b0, d};
  endfunction

  task automatic set_model(input logic [16:0] e);
    cur_ovf = e[16];
    for (int i = 0; i < 4; i++) cur_disp[i] = e[i*4 +: 4];
  endtask

  function automatic int an2idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold;
    int idx;
    idx = an2idx(an);
    chk_eq("an_onehot", idx >= 0, 1);
    if (idx >= 0) chk_eq($sformatf("hold_digit%0d", idx), bcd_cur, cur_disp[idx]);
  endtask

  task automatic start_conv(input int v);
    int guard;
    guard = 0;
    while (bus.busy && guard < 50) begin
      tick;
      guard++;
    end
    chk_eq("idle_before_load", bus.busy, 0);
    sb_q.push_back(model(v));
    bus.val_in = 14'(v);
    bus.load   = 1'b1;
    tick;
    bus.load   = 1'b0;
  endtask

  task automatic run_conv(input int exp_len);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      chk_eq("no_early_done", bus.done, 0);
      check_hold;
      cnt++;
      tick;
    end
    chk_eq("busy_len", cnt, exp_len);
    chk_eq("done_rise", bus.done, 1);
    check_hold;
    chk_eq("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) set_model(sb_q.pop_front());
    tick;
    chk_eq("done_pulse", bus.done, 0);
  endtask

  task automatic verify_display;
    bit seen [4];
    int idx;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    chk_eq("overflow", bus.overflow, cur_ovf);
    for (int c = 0; c < 24; c++) begin
      idx = an2idx(an);
      if (idx >= 0 && !seen[idx]) begin
        chk_eq($sformatf("digit%0d", idx), bcd_cur, cur_disp[idx]);
        seen[idx] = 1'b1;
      end
      tick;
    end
    for (int i = 0; i < 4; i++) chk_eq($sformatf("digit%0d_seen", i), seen[i], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          vals [7];
    int          cnt;
    int          ndone;
    logic [3:0]  prev;

    vals = '{1234, 7, 0, 1005, 10000, 16383, 42};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.load   = 1'b0;
    bus.val_in = '0;
    set_model(model(0));

    // Reset state
    repeat (3) tick;
    chk_eq("rst_an", an, 4'b1110);
    chk_eq("rst_bcd", bcd_cur, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_done", bus.done, 0);
    chk_eq("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;

    // Scan rotation
    prev = an;
    cnt  = 0;
    while (an == prev && cnt < 10) begin
      tick;
      cnt++;
    end
    chk_eq("scan_first", an, 4'b1101);
    for (int k = 0; k < 4; k++) begin
      prev = an;
      cnt  = 0;
      while (an == prev && cnt < 10) begin
        tick;
        cnt++;
      end
      chk_eq("scan_period", cnt, 4);
      chk_eq("scan_next", an, {prev[2:0], prev[3]});
    end

    // Plain conversions, including zero, internal zeros and overflow
    for (int i = 0; i < 7; i++) begin
      start_conv(vals[i]);
      run_conv(14);
      verify_display;
    end

    // load held high every cycle: one acceptance per conversion
    sb_q.push_back(model(56));
    sb_q.push_back(model(9087));
    bus.val_in = 14'd56;
    bus.load   = 1'b1;
    tick;
    bus.val_in = 14'd9087;
    run_conv(14);
    chk_eq("reaccept_busy", bus.busy, 1);
    bus.load = 1'b0;
    run_conv(14);
    verify_display;

    // Reset in the middle of a conversion
    start_conv(9999);
    repeat (7) tick;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_busy", bus.busy, 0);
    chk_eq("midrst_done", bus.done, 0);
    chk_eq("midrst_an", an, 4'b1110);
    chk_eq("midrst_bcd", bcd_cur, 0);
    chk_eq("midrst_ovf", bus.overflow, 0);
    sb_q.delete();
    set_model(model(0));
    tick;
    tick;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (bus.done) ndone++;
    end
    chk_eq("no_done_after_rst", ndone, 0);
    chk_eq("idle_after_rst", bus.busy, 0);
    verify_display;
    start_conv(1234);
    run_conv(14);
    verify_display;
    chk_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
